rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, e.g. a decoded 2-to-4 select path, between four masters. It produces a registered one-hot grant plus the matching 2-bit encoded index, so the index can drive the shared 2-to-4 decoder directly. A grant is held while its requester keeps asserting, up to a programmable quantum. Fairness comes from a rotating priority pointer.

---
 rtl/rr_arbiter4_if.sv | 34 +++
 rtl/rr_arbiter4.sv | 125 ++++++++++++
 tb/tb_rr_arbiter4.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between four masters and rr_arbiter4
//
// Signals:
//   req       [3:0]        request vector, bit i = requester i (driven by masters)
//   gnt       [3:0]        registered one-hot grant, zero when idle
//   gnt_idx   [1:0]        encoded index of the granted requester, 0 when idle
//   gnt_valid              high when any gnt bit is high
//   hold_cnt  [CNT_W-1:0]  cycles the current grant has been held (debug)
// Modports: master drives req and observes the grant; slave is the arbiter side.
interface rr_arbiter4_if #(
    parameter int CNT_W = 4
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  hold_cnt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output hold_cnt
    );
endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold quantum
//
// Parameters:
//   QUANTUM  max consecutive cycles a grant is held while others wait; 0 = unlimited
//   CNT_W    hold counter width, 2**CNT_W must exceed QUANTUM
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      rr_arbiter4_if.slave: req in; gnt, gnt_idx, gnt_valid, hold_cnt out
// All outputs are registered; there is no combinational path from req to gnt.
module rr_arbiter4 #(
    parameter int QUANTUM = 8,
    parameter int CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter4_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam bit               Q_EN   = (QUANTUM != 0);
    localparam logic [CNT_W-1:0] Q_LAST = Q_EN ? CNT_W'(QUANTUM - 1) : {CNT_W{1'b0}};

    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_valid;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [1:0]       r_ptr;      // last granted index + 1: just-served master goes last

    logic [3:0]       w_others;
    logic             w_cur_req;
    logic [1:0]       w_pick_req;
    logic [1:0]       w_pick_oth;
    logic             w_q_hit;

    // First set bit of mask scanning p, p+1, p+2, p+3 (mod 4).
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        // r_gnt is the one-hot of the current holder, so it doubles as the self-mask
        w_others   = bus.req & ~r_gnt;
        w_cur_req  = |(bus.req & r_gnt);
        w_pick_req = pick(r_ptr, bus.req);
        w_pick_oth = pick(r_ptr, w_others);
        w_q_hit    = Q_EN && (r_hold_cnt == Q_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_ptr       <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req != 4'b0000) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= 4'b0001 << w_pick_req;
                        r_gnt_idx   <= w_pick_req;
                        r_gnt_valid <= 1'b1;
                        r_ptr       <= w_pick_req + 2'd1;
                        r_hold_cnt  <= '0;
                    end
                end
                ST_GRANT: begin
                    if ((!w_cur_req || w_q_hit) && (w_others != 4'b0000)) begin
                        // holder released or quantum expired with someone waiting:
                        // hand over on this edge, no idle bubble
                        r_gnt      <= 4'b0001 << w_pick_oth;
                        r_gnt_idx  <= w_pick_oth;
                        r_ptr      <= w_pick_oth + 2'd1;
                        r_hold_cnt <= '0;
                    end else if (!w_cur_req) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= 4'b0000;
                        r_gnt_idx   <= 2'd0;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= '0;
                    end else if (w_q_hit) begin
                        // nobody waiting: keep the grant and restart the quantum
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
                        // saturate instead of wrapping (only reachable with QUANTUM=0)
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt       <= 4'b0000;
                    r_gnt_idx   <= 2'd0;
                    r_gnt_valid <= 1'b0;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.hold_cnt  = r_hold_cnt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4 (QUANTUM=8 and QUANTUM=0)
module tb_rr_arbiter4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    rr_arbiter4_if #(.CNT_W(4)) bus0 ();
    rr_arbiter4_if #(.CNT_W(4)) bus1 ();

    rr_arbiter4 #(.QUANTUM(8), .CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rr_arbiter4 #(.QUANTUM(0), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: per-DUT arbitration state in plain integers.
    int m_act  [2];
    int m_cur  [2];
    int m_ptr  [2];
    int m_hold [2];
    int m_q    [2] = '{8, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int model_pick(input int p, input int mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[(p + i) % 4]) return (p + i) % 4;
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_cur[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
        end
    endtask

    task automatic model_grant(input int k, input int mask);
        m_cur[k]  = model_pick(m_ptr[k], mask);
        m_ptr[k]  = (m_cur[k] + 1) % 4;
        m_hold[k] = 0;
        m_act[k]  = 1;
    endtask

    task automatic model_step(input int k, input int rq);
        int others;
        others = rq & ~(1 << m_cur[k]);
        if (m_act[k] == 0) begin
            if (rq != 0) model_grant(k, rq);
        end else if (rq[m_cur[k]] == 1'b0) begin
            if (others != 0) model_grant(k, others);
            else begin m_act[k] = 0; m_hold[k] = 0; end
        end else if (m_q[k] != 0 && m_hold[k] == m_q[k] - 1) begin
            if (others != 0) model_grant(k, others);
            else m_hold[k] = 0;
        end else begin
            m_hold[k] = (m_hold[k] >= 15) ? 15 : m_hold[k] + 1;
        end
    endtask

    task automatic compare_dut(input int k, input int g, input int idx, input int v, input int h);
        int eg;
        eg = m_act[k] ? (1 << m_cur[k]) : 0;
        check($sformatf("d%0d_gnt", k), g, eg);
        check($sformatf("d%0d_idx", k), idx, m_act[k] ? m_cur[k] : 0);
        check($sformatf("d%0d_valid", k), v, m_act[k]);
        check($sformatf("d%0d_hold", k), h, m_act[k] ? m_hold[k] : 0);
    endtask

    always @(negedge rst_n) model_reset();

    // Advance model on each edge from the sampled req, then compare 1 time unit later.
    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0, int'(bus0.req));
            model_step(1, int'(bus1.req));
        end else begin
            model_reset();
        end
        #1;
        compare_dut(0, int'(bus0.gnt), int'(bus0.gnt_idx), int'(bus0.gnt_valid), int'(bus0.hold_cnt));
        compare_dut(1, int'(bus1.gnt), int'(bus1.gnt_idx), int'(bus1.gnt_valid), int'(bus1.hold_cnt));
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus0.req = 4'b0000;
        bus1.req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] vec_tbl [12] = '{4'b0101, 4'b0101, 4'b0100, 4'b1010, 4'b0000, 4'b1000,
                                 4'b1111, 4'b0011, 4'b0110, 4'b0000, 4'b1001, 4'b0001};

    initial begin
        bus0.req = 4'b0000;
        bus1.req = 4'b0000;
        do_reset();

        // 1: idle after reset
        for (int c = 0; c < 5; c++) begin
            after_edge();
            check("idle_gnt", int'(bus0.gnt), 0);
            check("idle_valid", int'(bus0.gnt_valid), 0);
            check("idle_idx", int'(bus0.gnt_idx), 0);
        end

        // 2: all requesting, quantum 8 rotation 0,1,2,3,0
        @(negedge clk);
        bus0.req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            after_edge();
            check("rot_gnt", int'(bus0.gnt), 1 << ((c / 8) % 4));
            check("rot_idx", int'(bus0.gnt_idx), (c / 8) % 4);
            check("rot_hold", int'(bus0.hold_cnt), c % 8);
        end

        // 1b: asynchronous reset mid-grant
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", int'(bus0.gnt), 0);
        check("arst_valid", int'(bus0.gnt_valid), 0);
        check("arst_hold", int'(bus0.hold_cnt), 0);
        bus0.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // 3: lone requester, grant continuous, hold wraps 7->0
        @(negedge clk);
        bus0.req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            after_edge();
            check("lone_gnt", int'(bus0.gnt), 4'b0100);
            check("lone_hold", int'(bus0.hold_cnt), c % 8);
        end
        @(negedge clk);
        bus0.req = 4'b0000;
        after_edge();
        check("lone_release", int'(bus0.gnt), 0);

        // 4: requester 1 granted, then 0010 -> 1001 switches straight to 3
        @(negedge clk);
        bus0.req = 4'b0010;
        after_edge();
        check("sw_first", int'(bus0.gnt), 4'b0010);
        @(negedge clk);
        bus0.req = 4'b1001;
        after_edge();
        check("sw_gnt", int'(bus0.gnt), 4'b1000);
        check("sw_idx", int'(bus0.gnt_idx), 3);
        check("sw_valid", int'(bus0.gnt_valid), 1);

        // 5: single-cycle pulse from idle, then 0011 goes to 1 first
        do_reset();
        bus0.req = 4'b0001;
        after_edge();
        check("pulse_gnt", int'(bus0.gnt), 4'b0001);
        @(negedge clk);
        bus0.req = 4'b0000;
        after_edge();
        check("pulse_end", int'(bus0.gnt), 0);
        @(negedge clk);
        bus0.req = 4'b0011;
        after_edge();
        check("ptr_gnt", int'(bus0.gnt), 4'b0010);

        // directed vectors checked by the model
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus0.req = vec_tbl[i];
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        bus0.req = 4'b0000;

        // 6: unlimited quantum, hold saturates at 15
        do_reset();
        bus1.req = 4'b0011;
        for (int c = 0; c < 40; c++) begin
            after_edge();
            check("q0_gnt", int'(bus1.gnt), 4'b0001);
            check("q0_hold", int'(bus1.hold_cnt), (c > 15) ? 15 : c);
        end
        @(negedge clk);
        bus1.req = 4'b0010;
        after_edge();
        check("q0_drop_gnt", int'(bus1.gnt), 4'b0010);
        check("q0_drop_hold", int'(bus1.hold_cnt), 0);

        // starvation: requester 3 held, others churn; must be served within 3*8+1
        do_reset();
        bus0.req = 4'b0111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus0.req = 4'b1111;
        begin
            int waited;
            waited = 0;
            while (bus0.gnt != 4'b1000 && waited < 30) begin
                after_edge();
                waited++;
            end
            checks++;
            if (waited > 25) begin
                errors++;
                $display("FAIL starve: waited %0d cycles limit 25", waited);
            end
        end

        @(negedge clk);
        bus0.req = 4'b0000;
        bus1.req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
